// File: rtl/tdm_demux2.sv
// tdm_demux2: two-channel TDM serial demultiplexer; define TDM_DEMUX2_PARITY_EN for per-slot even parity
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             din,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch0_valid,
  output logic             ch1_valid,
  output logic             busy,
  output logic             frame_err
);
`ifdef TDM_DEMUX2_PARITY_EN
  localparam int S = WIDTH + 1;
`else
  localparam int S = WIDTH;
`endif
  localparam int CW = $clog2(S);
  typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [S-2:0] sr, sr_n;
  logic [S-1:0] word;
  logic [WIDTH-1:0] ch0_n, ch1_n;
  logic v0_n, v1_n, err_n, last, good, done;
  assign word = {sr, din};
`ifdef TDM_DEMUX2_PARITY_EN
  assign good = ~^word;
`else
  assign good = 1'b1;
`endif
  assign last = cnt == CW'(S - 1);
  assign done = state != IDLE && !sync && last;
  assign busy = state != IDLE;
  // next-state: sync always (re)starts a frame, aborting any frame in progress
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    err_n = 1'b0;
    if (sync) begin
      state_n = CH0;
      cnt_n = CW'(1);
      sr_n = (S-1)'(din);
      err_n = state != IDLE;
    end else if (state != IDLE) begin
      sr_n = word[S-2:0];
      cnt_n = last ? '0 : cnt + 1'b1;
      state_n = !last ? state : state == CH0 ? CH1 : IDLE;
      err_n = last && !good;
    end
    v0_n = done && good && state == CH0;
    v1_n = done && good && state == CH1;
    ch0_n = v0_n ? word[S-1 -: WIDTH] : ch0_data;
    ch1_n = v1_n ? word[S-1 -: WIDTH] : ch1_data;
  end
  // state and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ch0_data <= '0;
      ch1_data <= '0;
      ch0_valid <= 1'b0;
      ch1_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      ch0_data <= ch0_n;
      ch1_data <= ch1_n;
      ch0_valid <= v0_n;
      ch1_valid <= v1_n;
      frame_err <= err_n;
    end
endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: scoreboard bench for tdm_demux2 (WIDTH=8); TDM_DEMUX2_PARITY_EN selects parity slots
module tb_tdm_demux2;
`ifdef TDM_DEMUX2_PARITY_EN
  localparam int S = 9;
`else
  localparam int S = 8;
`endif
  logic clk = 0, reset = 0, sync = 0, din = 0;
  logic [7:0] ch0_data, ch1_data;
  logic ch0_valid, ch1_valid, busy, frame_err;
  typedef struct {int cyc; logic [7:0] d;} ev_t;
  ev_t q0[$], q1[$];
  int qe[$];
  int cyc = 0, n_checks = 0, n_fail = 0;
  logic [7:0] m0 = 0, m1 = 0;
  bit e0, e1, ee;

  tdm_demux2 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sync(sync), .din(din),
    .ch0_data(ch0_data), .ch1_data(ch1_data),
    .ch0_valid(ch0_valid), .ch1_valid(ch1_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #2;
    e0 = q0.size() > 0 && q0[0].cyc == cyc;
    e1 = q1.size() > 0 && q1[0].cyc == cyc;
    ee = qe.size() > 0 && qe[0] == cyc;
    if (e0) begin m0 = q0[0].d; void'(q0.pop_front()); end
    if (e1) begin m1 = q1[0].d; void'(q1.pop_front()); end
    if (ee) void'(qe.pop_front());
    n_checks += 5;
    if (ch0_valid !== e0) begin n_fail++; $display("FAIL ch0_valid cycle %0d: got %b expected %b", cyc, ch0_valid, e0); end
    if (ch1_valid !== e1) begin n_fail++; $display("FAIL ch1_valid cycle %0d: got %b expected %b", cyc, ch1_valid, e1); end
    if (frame_err !== ee) begin n_fail++; $display("FAIL frame_err cycle %0d: got %b expected %b", cyc, frame_err, ee); end
    if (ch0_data !== m0) begin n_fail++; $display("FAIL ch0_data cycle %0d: got %h expected %h", cyc, ch0_data, m0); end
    if (ch1_data !== m1) begin n_fail++; $display("FAIL ch1_data cycle %0d: got %h expected %h", cyc, ch1_data, m1); end
  end

  task automatic drive(input logic s, input logic d);
    sync = s;
    din = d;
    @(posedge clk);
    #1;
    sync = 0;
  endtask

  task automatic send_slot(input logic first, input logic [7:0] d, input bit bad);
    for (int i = 7; i >= 0; i--) drive(first && i == 7, d[i]);
`ifdef TDM_DEMUX2_PARITY_EN
    drive(1'b0, bad ? ~^d : ^d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input bit bad0, input bit bad1);
    int c0 = cyc;
    if (bad0) qe.push_back(c0 + S); else q0.push_back('{c0 + S, d0});
    if (bad1) qe.push_back(c0 + 2*S); else q1.push_back('{c0 + 2*S, d1});
    send_slot(1'b1, d0, bad0);
    send_slot(1'b0, d1, bad1);
  endtask

  task automatic test_reset;
    #3 reset = 1;
    #1;
    n_checks++;
    if ({ch0_data, ch1_data, ch0_valid, ch1_valid, busy, frame_err} !== 20'h0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", {ch0_data, ch1_data, ch0_valid, ch1_valid, busy, frame_err});
    end
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, i[0]);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy cycle %0d: got %b expected 0", cyc, busy); end
    end
  endtask

  task automatic test_single;
    send_frame(8'hA5, 8'h3C, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    drive(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    send_frame(8'hA5, 8'h3C, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: got %b expected 0", busy); end
    send_frame(8'hFF, 8'h00, 0, 0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_abort;
    logic [7:0] p = 8'h96;
    int c0 = cyc;
    q0.push_back('{c0 + S, 8'h5A});
    send_slot(1'b1, 8'h5A, 0);
    for (int i = 7; i > 4; i--) drive(1'b0, p[i]);
    qe.push_back(cyc + 1);
    send_frame(8'hC3, 8'h81, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_abort_busy;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    qe.push_back(cyc + 1);
    drive(1'b1, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b expected 1", busy); end
    q0.push_back('{cyc - 1 + S, 8'hB4});
    for (int i = 6; i >= 0; i--) drive(1'b0, 8'(8'hB4 >> i) & 1'b1);
`ifdef TDM_DEMUX2_PARITY_EN
    drive(1'b0, ^8'hB4);
`endif
    q1.push_back('{cyc + S, 8'h4B});
    send_slot(1'b0, 8'h4B, 0);
  endtask

  task automatic test_mid_reset;
    logic [7:0] p = 8'h77;
    for (int i = 7; i > 2; i--) drive(i == 7, p[i]);
    #2 reset = 1;
    #1;
    m0 = 0;
    m1 = 0;
    n_checks++;
    if ({ch0_data, ch1_data, ch0_valid, ch1_valid, busy, frame_err} !== 20'h0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0", {ch0_data, ch1_data, ch0_valid, ch1_valid, busy, frame_err});
    end
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    send_frame(8'hE7, 8'h18, 0, 0);
  endtask

`ifdef TDM_DEMUX2_PARITY_EN
  task automatic test_parity;
    send_frame(8'hA5, 8'h3C, 1, 0);
    send_frame(8'h12, 8'h34, 0, 1);
  endtask
`endif

  initial begin
    test_reset;
    test_idle;
    test_single;
    test_back_to_back;
    test_abort;
    test_abort_busy;
    test_mid_reset;
`ifdef TDM_DEMUX2_PARITY_EN
    test_parity;
`endif
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
    n_checks++;
    if (q0.size() + q1.size() + qe.size() != 0) begin
      n_fail++; $display("FAIL pending_events: got %0d expected 0", q0.size() + q1.size() + qe.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux2.md
# tdm_demux2

Two-channel time-division demultiplexer: the receive end of the 2:1 serial multiplexing path. A frame of one sync-marked serial bit stream carries one channel-0 word followed by one channel-1 word. The block deserialises the frame, presents each word on its own registered output, and flags each with a one-cycle valid pulse. It sits between the board-level serial input and the per-channel LED/display logic.

## Interface
- WIDTH, 8, bits per channel word (≥ 2)
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- sync  input  1  frame start; high in the cycle `din` carries channel-0 MSB
- din  input  1  serial data, MSB first, one bit per clk cycle
- ch0_data  output  WIDTH  last completed channel-0 word (registered)
- ch1_data  output  WIDTH  last completed channel-1 word (registered)
- ch0_valid  output  1  one-cycle pulse: ch0_data just updated
- ch1_valid  output  1  one-cycle pulse: ch1_data just updated
- busy  output  1  high while a frame is in progress (state ≠ IDLE)
- frame_err  output  1  one-cycle pulse on frame abort or parity failure

## Operation
- Reset values: all outputs 0; state IDLE; shift register and bit counter 0.
- States: IDLE, CH0, CH1.
- IDLE: `din` is ignored while `sync`=0. A sample with `sync`=1 takes `din` as ch0 bit WIDTH-1, sets counter to 1, and moves to CH0.
- CH0: shifts `din` in MSB-first each cycle. When slot bit count is reached, loads `ch0_data`, pulses `ch0_valid`, clears the counter, and moves to CH1.
- CH1: same operation for channel 1. On completion it loads `ch1_data`, pulses `ch1_valid`, and returns to IDLE.
- Back-to-back frames: `sync` is legal in the cycle right after the last ch1 bit (IDLE at that point). No gap cycle is required.
- Mid-frame `sync` (state CH0 or CH1):
  - The frame is aborted and `frame_err` pulses.
  - The partial word is discarded. A channel-0 word already delivered in this frame stands.
  - The sampled bit starts a new frame as ch0 MSB, same as `sync` in IDLE.
- Outputs hold their value between updates. A channel only updates on a good completion.
- Reset mid-frame drops the frame immediately: no valid, no error.

## Timing
- Cycle 0 is the cycle with `sync`=1. With S = slot bits (WIDTH, or WIDTH+1 with parity):
  - ch0 bits are sampled in cycles 0..S-1.
  - `ch0_data` and `ch0_valid` are visible in cycle S.
  - ch1 bits are sampled in cycles S..2S-1.
  - `ch1_data` and `ch1_valid` are visible in cycle 2S.
- `busy` is high in cycles 1..2S-1 and low in cycle 2S unless a new `sync` arrived in cycle 2S-1... `sync` in cycle 2S keeps `busy` high from cycle 2S+1.
- `frame_err` appears the cycle after the offending sample.
- Latency from the last bit of a word to its valid pulse is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `TDM_DEMUX2_PARITY_EN` defined:
  - Each slot is WIDTH data bits followed by 1 even-parity bit, so S = WIDTH+1.
  - On a parity mismatch the channel's data is not updated, its valid is not pulsed, and `frame_err` pulses in cycle S (or 2S).
  - The frame continues normally: a ch0 parity error does not abort ch1.
- Not defined: S = WIDTH, no parity checking, and `frame_err` is raised only by mid-frame `sync`.

## Test plan
- Reset/idle (WIDTH=8): assert `reset` asynchronously mid-cycle -> all outputs 0 at once. Then `din` toggles with `sync`=0 for 20 cycles -> no valid, `busy`=0.
- Single frame: `sync` at cycle 0, bits 0xA5 then 0x3C -> `ch0_data`=0xA5 with `ch0_valid` in cycle 8; `ch1_data`=0x3C with `ch1_valid` in cycle 16; `frame_err`=0.
- Back-to-back frames: second `sync` in cycle 16 carrying 0xFF, 0x00 -> valids in cycles 8, 16, 24, 32; data 0xA5/0x3C then 0xFF/0x00.
- Mid-frame abort: `sync` again at ch1 bit 3 (cycle 11) -> `frame_err` in cycle 12, `ch1_data` unchanged, new ch0 word valid in cycle 19.
- Reset mid-frame: assert `reset` at cycle 5 of a frame -> no valid pulses, and the next `sync` frame decodes correctly.
- Parity (macro defined): ch0 0xA5 with a wrong parity bit, ch1 0x3C with correct parity -> `frame_err` in cycle 9, no `ch0_valid`; `ch1_valid` in cycle 18 with 0x3C.
